// File: rtl/mem_arb_pkg.sv
// Shared state encoding and block-address constants for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, FILL_D, FILL_I} arb_state_t;

  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
  localparam int          WORD_STRIDE = 2;

endpackage

// File: rtl/mem_fill_sequencer.sv
// Block-fill sequencer: issues WORDS pipelined reads from a block-aligned base
// and counts the returned words, flagging the last one.
module fill_sequencer
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int WORDS   = 8,
  parameter int ADDR_W  = 16,
  parameter int IDX_W   = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              data_valid,
  output logic              issue,
  output logic [ADDR_W-1:0] issue_addr,
  output logic              recv_we,
  output logic [IDX_W-1:0]  recv_idx,
  output logic              done
);

  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam int LAT_W = $clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(~BLOCK_MASK);

  logic              active;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [LAT_W-1:0]  lat_tmr;
  logic [ADDR_W-1:0] base;

  assign issue      = active && (issue_cnt < CNT_W'(WORDS));
  assign issue_addr = issue ? base + ADDR_W'(issue_cnt * WORD_STRIDE) : '0;

  // The first word cannot return sooner than LATENCY cycles after its read; earlier valids are stray.
  assign recv_we  = active && data_valid && (lat_tmr == '0);
  assign recv_idx = recv_cnt[IDX_W-1:0];
  assign done     = recv_we && (recv_cnt == CNT_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (abort) begin
      active    <= 1'b0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      lat_tmr   <= '0;
      base      <= '0;
    end else if (start) begin
      active    <= 1'b1;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      lat_tmr   <= LAT_W'(LATENCY);
      base      <= start_addr & BASE_MASK;
    end else if (active) begin
      if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
      if (lat_tmr != '0) lat_tmr <= lat_tmr - LAT_W'(1);
      if (recv_we) recv_cnt <= recv_cnt + CNT_W'(1);
      if (done) begin
        active    <= 1'b0;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares the main-memory port between D-cache stores, D-cache fills and I-cache fills.
//   state  | meaning
//   IDLE   | no access; samples requests (store > D miss > I miss)
//   WRITE  | one-cycle write-through store, acked this cycle
//   FILL_D | 8-word block fill into the D-cache
//   FILL_I | 8-word block fill into the I-cache
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int WORDS   = 8,
  parameter int ADDR_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_miss,
  input  logic [ADDR_W-1:0]        icache_miss_addr,
  input  logic                     dcache_miss,
  input  logic [ADDR_W-1:0]        dcache_miss_addr,
  input  logic                     dcache_wr,
  input  logic [ADDR_W-1:0]        dcache_wr_addr,
  input  logic [15:0]              dcache_wr_data,
  input  logic [15:0]              mem_rdata,
  input  logic                     mem_data_valid,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [15:0]              mem_wdata,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word_idx,
  output logic                     icache_fill_we,
  output logic                     dcache_fill_we,
  output logic                     icache_fill_done,
  output logic                     dcache_fill_done,
  output logic                     dcache_wr_ack,
  output logic                     stall_fetch,
  output logic                     stall_mem,
  output logic                     busy
);

  arb_state_t        state, state_nxt;
  logic              seq_start;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_issue;
  logic [ADDR_W-1:0] seq_issue_addr;
  logic              seq_we;
  logic              seq_done;
  logic              is_write;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seq_start = 1'b0;
    seq_addr  = '0;
    case (state)
      IDLE: begin
        if (dcache_wr) begin
          state_nxt = WRITE;
        end else if (dcache_miss) begin
          state_nxt = FILL_D;
          seq_start = 1'b1;
          seq_addr  = dcache_miss_addr;
        end else if (icache_miss) begin
          state_nxt = FILL_I;
          seq_start = 1'b1;
          seq_addr  = icache_miss_addr;
        end
      end
      WRITE:          state_nxt = IDLE;
      FILL_D, FILL_I: if (seq_done) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  fill_sequencer #(
    .LATENCY (LATENCY),
    .WORDS   (WORDS),
    .ADDR_W  (ADDR_W)
  ) u_seq (
    .clk        (clk),
    .start      (seq_start),
    .abort      (~rst),
    .start_addr (seq_addr),
    .data_valid (mem_data_valid),
    .issue      (seq_issue),
    .issue_addr (seq_issue_addr),
    .recv_we    (seq_we),
    .recv_idx   (fill_word_idx),
    .done       (seq_done)
  );

  assign is_write = (state == WRITE);

  assign mem_en    = is_write | seq_issue;
  assign mem_wr    = is_write;
  assign mem_addr  = is_write ? dcache_wr_addr : seq_issue_addr;
  assign mem_wdata = is_write ? dcache_wr_data : 16'h0000;

  assign fill_data        = mem_rdata;
  assign icache_fill_we   = (state == FILL_I) & seq_we;
  assign dcache_fill_we   = (state == FILL_D) & seq_we;
  assign icache_fill_done = (state == FILL_I) & seq_done;
  assign dcache_fill_done = (state == FILL_D) & seq_done;
  assign dcache_wr_ack    = is_write;

  assign stall_fetch = icache_miss & ~icache_fill_done;
  assign stall_mem   = (dcache_miss & ~dcache_fill_done) | (dcache_wr & ~dcache_wr_ack);
  assign busy        = (state != IDLE);

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares the single main-memory port between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sequences each miss as an 8-word pipelined block fill and steers the returned words into the requesting cache.
- Generates the fetch and memory-stage stall signals.
- Sits between the Fetch stage's I-cache, the MEM stage's D-cache and the 4-cycle-latency main memory.

Parameters:
- LATENCY, 4, cycles from a memory read issue to its mem_data_valid.
- WORDS, 8, 16-bit words per cache block (16-byte block).
- ADDR_W, 16, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low
- icache_miss  in  1  I-cache miss; held until icache_fill_done
- icache_miss_addr  in  ADDR_W  missing fetch address
- dcache_miss  in  1  D-cache read/write-allocate miss; held until dcache_fill_done
- dcache_miss_addr  in  ADDR_W  missing data address
- dcache_wr  in  1  write-through store request; held until dcache_wr_ack
- dcache_wr_addr  in  ADDR_W  store address
- dcache_wr_data  in  16  store data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  mem_rdata valid this cycle
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  16  memory write data
- fill_data  out  16  word being written into a cache (= mem_rdata)
- fill_word_idx  out  3  word index within the block
- icache_fill_we  out  1  write fill_data into the I-cache
- dcache_fill_we  out  1  write fill_data into the D-cache
- icache_fill_done  out  1  one-cycle pulse, I block complete
- dcache_fill_done  out  1  one-cycle pulse, D block complete
- dcache_wr_ack  out  1  one-cycle pulse, store issued
- stall_fetch  out  1  stall PC/IF-ID
- stall_mem  out  1  stall the whole pipeline at MEM
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; issue_cnt and recv_cnt = 0.
  - All registered outputs = 0.
  - Memory shares rst, so there are no stale returns. An in-progress fill is abandoned, no done pulse.
- States: IDLE, WRITE, FILL_D, FILL_I.
- IDLE, fixed priority on registered sampling:
  - dcache_wr → WRITE.
  - else dcache_miss → FILL_D.
  - else icache_miss → FILL_I.
  - Base address latched as miss_addr & ~0xF.
- WRITE (1 cycle):
  - mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data.
  - dcache_wr_ack=1, then → IDLE.
- FILL_x issue phase: while issue_cnt<WORDS, mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt++.
  - Word k is issued in cycle k of the state (k=0..7).
- FILL_x return phase: on each mem_data_valid, fill_data=mem_rdata, fill_word_idx=recv_cnt, the matching fill_we=1, recv_cnt++.
- Last word (recv_cnt==WORDS-1 with valid): the matching fill_done pulses in the same cycle; → IDLE next cycle; counters cleared.
- Timing: request seen in IDLE at cycle 0 → issues in cycles 1..8 → valids in cycles 5..12 → done at cycle 12 → IDLE at cycle 13.
- mem_data_valid while IDLE or WRITE is ignored; no fill_we.
- No preemption:
  - A D request arriving during FILL_I waits until FILL_I completes.
  - A D request arriving during FILL_D waits until FILL_D completes.
  - Then priority is re-evaluated.
- Simultaneous icache_miss and dcache_miss: D first. I starts the cycle after dcache_fill_done (IDLE cycle, then FILL_I).
- Combinational stalls:
  - stall_fetch = icache_miss & ~icache_fill_done.
  - stall_mem = (dcache_miss & ~dcache_fill_done) | (dcache_wr & ~dcache_wr_ack).
- Address arithmetic wraps modulo 2^ADDR_W; base 0xFFF0 issues 0xFFF0..0xFFFE.
- mem_addr and mem_wdata = 0 when mem_en=0.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, WRITE, FILL_D, FILL_I}
  - localparams BLOCK_MASK=16'hFFF0 and WORD_STRIDE=2
- One sub-module, fill_sequencer, holds:
  - issue/recv counters, base register, address generation, last-word detect.
  - Start/abort inputs; done output.
- Top level holds the arbiter FSM and output steering.

Test Plan:
- icache_miss, addr 0x1236, alone:
  - mem reads issued to 0x1230..0x123E in cycles 1..8.
  - icache_fill_we on cycles 5..12 with idx 0..7.
  - icache_fill_done at cycle 12; stall_fetch 1 on cycles 0..11, 0 on cycle 12.
- icache_miss (0x0040) and dcache_miss (0x2008) in the same cycle:
  - D fill of 0x2000..0x200E completes first.
  - I fill starts issuing 0x0040 two cycles after dcache_fill_done.
  - No icache_fill_we during the D fill.
- dcache_wr (0x3002, 0xBEEF) arriving during cycle 3 of FILL_I:
  - Waits for the I fill to finish; then one cycle mem_en=1, mem_wr=1, addr 0x3002, data 0xBEEF, dcache_wr_ack=1.
  - stall_mem held high until that cycle.
- dcache_wr and dcache_miss asserted together: WRITE is served first, then FILL_D with no idle gap beyond one IDLE cycle.
- rst=0 at cycle 6 of FILL_D:
  - Next cycle state=IDLE, all outputs 0, no dcache_fill_done.
  - A re-asserted miss restarts from word 0.
- Miss address 0xFFF4: issues 0xFFF0..0xFFFE with no carry into the next block; spurious mem_data_valid in IDLE produces no fill_we.
